uart_rx: RTL and testbench

Serial-to-parallel UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It sits directly downstream of `uart_tx` and consumes its `tx_data` line, either in loopback or from an external pin. It delivers each received byte on `dout` with a one-cycle `rx_done` strobe, and flags bad stop bits on `frame_err`.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the default bit period.
// The transmitter imports this same package so the bit period has a single source.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both stages reset high so that a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling of the synchronized line.
// A low stop bit reports frame_err and parks in BREAK until the line returns high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_data,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      rx_done,
  output logic                      frame_err,
  output logic                      rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_state_e               state_d, state_q;
  logic [CW-1:0]             cnt_d, cnt_q;
  logic [2:0]                bit_idx_d, bit_idx_q;
  logic [UART_DATA_BITS-1:0] sh_d, sh_q;
  logic [UART_DATA_BITS-1:0] dout_d, dout_q;
  logic                      rx_done_d, rx_done_q;
  logic                      frame_err_d, frame_err_q;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_data),
    .q   (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    sh_d        = sh_q;
    dout_d      = dout_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      // A start bit must still be low at its midpoint, otherwise it was a glitch.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == IDX_LAST) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            dout_d    = sh_q;
            rx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      sh_q        <= '0;
      dout_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      sh_q        <= sh_d;
      dout_q      <= dout_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign dout      = dout_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a behavioural transmitter drives the line
// and a monitor logs every rx_done byte, its time, and every frame_err pulse.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] doneQ[$];
  time        doneT[$];
  int         errCount  = 0;
  int         bothHigh  = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .dout      (dout),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Outputs are observed on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (rx_done) begin
      doneQ.push_back(dout);
      doneT.push_back($time);
    end
    if (frame_err) errCount++;
    if (rx_done && frame_err) bothHigh++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame starting at a falling edge; stopBit lets a frame be malformed.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_data = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx_data = 1'b1;
  endtask

  initial begin
    int  base;
    int  errBase;
    int  busyCycles;
    int  idleCycles;
    time t0;
    int  lat;
    logic [7:0] loopBytes[4];
    loopBytes[0] = 8'h6E;
    loopBytes[1] = 8'h06;
    loopBytes[2] = 8'hC3;
    loopBytes[3] = 8'hF0;

    rst     = 1'b1;
    rx_data = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_dout", {24'd0, dout}, 32'h00);
    checkOutput("reset_rx_done", {31'd0, rx_done}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    repeat (5) @(negedge clk);

    $display("[TB] loopback of four bytes");
    base    = doneQ.size();
    errBase = errCount;
    t0      = $time;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(loopBytes[i], 1'b1);
      repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checkOutput("loop_count", doneQ.size() - base, 32'd4);
    for (int i = 0; i < 4; i++)
      if (doneQ.size() > base + i)
        checkOutput($sformatf("loop_byte%0d", i), {24'd0, doneQ[base+i]}, {24'd0, loopBytes[i]});
    checkOutput("loop_frame_err", errCount - errBase, 32'd0);
    if (doneT.size() > base) begin
      lat = int'((doneT[base] - t0) / 10);
      checkOutput("loop_latency_window", {31'd0, (lat >= 154 && lat <= 157)}, 32'd1);
    end

    $display("[TB] back-to-back 0x00 then 0xFF");
    base = doneQ.size();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("b2b_count", doneQ.size() - base, 32'd2);
    if (doneQ.size() >= base + 2) begin
      checkOutput("b2b_first", {24'd0, doneQ[base]}, 32'h00);
      checkOutput("b2b_second", {24'd0, doneQ[base+1]}, 32'hFF);
      checkOutput("b2b_gap_cycles", 32'((doneT[base+1] - doneT[base]) / 10), 32'd160);
    end

    $display("[TB] three-cycle glitch on idle line");
    base       = doneQ.size();
    errBase    = errCount;
    busyCycles = 0;
    rx_data    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) rx_data = 1'b1;
      @(negedge clk);
      if (rx_busy) busyCycles++;
    end
    checkOutput("glitch_no_done", doneQ.size() - base, 32'd0);
    checkOutput("glitch_no_err", errCount - errBase, 32'd0);
    checkOutput("glitch_busy_seen", {31'd0, busyCycles > 0}, 32'd1);
    checkOutput("glitch_busy_bound", {31'd0, busyCycles <= 9}, 32'd1);
    checkOutput("glitch_back_idle", {31'd0, rx_busy}, 32'd0);

    $display("[TB] 0xA5 with low stop bit then 50-bit break");
    base       = doneQ.size();
    errBase    = errCount;
    idleCycles = 0;
    applyStimulus(8'hA5, 1'b0);
    rx_data = 1'b0;
    for (int i = 0; i < 50 * CPB; i++) begin
      @(negedge clk);
      if (!rx_busy) idleCycles++;
    end
    checkOutput("break_stays_busy", idleCycles, 32'd0);
    rx_data = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("break_err_pulses", errCount - errBase, 32'd1);
    checkOutput("break_no_done", doneQ.size() - base, 32'd0);
    checkOutput("break_dout_held", {24'd0, dout}, 32'hFF);
    checkOutput("break_released_idle", {31'd0, rx_busy}, 32'd0);

    $display("[TB] reset during data bit 4 of 0x3C");
    base    = doneQ.size();
    errBase = errCount;
    rx_data = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_data = (8'h3C >> i) & 1;
      repeat (CPB) @(negedge clk);
    end
    rx_data = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_dout", {24'd0, dout}, 32'h00);
    checkOutput("rst_rx_done", {31'd0, rx_done}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    repeat (200) @(negedge clk);
    checkOutput("rst_no_done", doneQ.size() - base, 32'd0);
    checkOutput("rst_no_err", errCount - errBase, 32'd0);
    applyStimulus(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput("after_rst_count", doneQ.size() - base, 32'd1);
    if (doneQ.size() > base)
      checkOutput("after_rst_byte", {24'd0, doneQ[base]}, 32'h81);
    checkOutput("after_rst_dout", {24'd0, dout}, 32'h81);

    checkOutput("done_err_exclusive", bothHigh, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
